// File: rtl/mig_req_gen.sv
// mig_req_gen: takes hot page indices, filters out recently migrated pages,
// and issues one cache-line read per line of each new page.
module mig_req_gen #(
  parameter int ADDR_SIZE       = 33,
  parameter int DATA_SIZE       = 21,
  parameter int LINE_OFFSET     = 6,
  parameter int HIST_DEPTH      = 8,
  parameter int MAX_OUTSTANDING = 16,
  parameter int QUERY_PERIOD    = 1024
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic                 hist_clear,
  output logic                 query_en,
  input  logic                 query_ready,
  input  logic                 mig_addr_en,
  input  logic [ADDR_SIZE-1:0] mig_addr,
  output logic                 mig_addr_ready,
  output logic                 rd_valid,
  output logic [ADDR_SIZE-1:0] rd_addr,
  input  logic                 rd_ready,
  input  logic                 rd_done,
  output logic                 busy,
  output logic [31:0]          mig_count,
  output logic [15:0]          dup_count
);
  localparam int LINE_IDX_SIZE  = ADDR_SIZE - DATA_SIZE - LINE_OFFSET;
  localparam int LINES_PER_PAGE = 2 ** LINE_IDX_SIZE;
  localparam int HP_W  = $clog2(HIST_DEPTH);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW    = QUERY_PERIOD > 1 ? $clog2(QUERY_PERIOD) : 1;

  typedef enum logic [1:0] {IDLE, CHECK, ISSUE, DRAIN} state_t;

  state_t                   state, state_n;
  logic [DATA_SIZE-1:0]     page;
  logic [LINE_IDX_SIZE-1:0] line_idx;
  logic [OUT_W-1:0]         outstanding;
  logic [DATA_SIZE-1:0]     hist_page [HIST_DEPTH];
  logic [HIST_DEPTH-1:0]    hist_vld;
  logic [HP_W-1:0]          hist_ptr;
  logic [TW-1:0]            timer;
  logic                     hit, accept, take, unused_hi;

  assign unused_hi      = ^mig_addr[ADDR_SIZE-1:DATA_SIZE];
  assign mig_addr_ready = rstn & enable & (state == IDLE);
  assign take           = mig_addr_en & mig_addr_ready;
  assign rd_valid       = (state == ISSUE) & (outstanding < OUT_W'(MAX_OUTSTANDING));
  assign rd_addr        = {page, line_idx, {LINE_OFFSET{1'b0}}};
  assign accept         = rd_valid & rd_ready;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < HIST_DEPTH; i++) hit = hit | (hist_vld[i] && hist_page[i] == page);
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  state_n = take ? CHECK : IDLE;
      CHECK: state_n = hit ? IDLE : ISSUE;
      ISSUE: state_n = (accept && line_idx == LINE_IDX_SIZE'(LINES_PER_PAGE - 1)) ? DRAIN : ISSUE;
      DRAIN: state_n = (outstanding == '0) ? IDLE : DRAIN;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      busy        <= 1'b0;
      page        <= '0;
      line_idx    <= '0;
      outstanding <= '0;
      hist_vld    <= '0;
      hist_ptr    <= '0;
      mig_count   <= '0;
      dup_count   <= '0;
    end else begin
      state       <= state_n;
      busy        <= state_n != IDLE;
      if (take) page <= mig_addr[DATA_SIZE-1:0];
      if (state == CHECK) line_idx <= '0;
      else if (accept) line_idx <= line_idx + 1'b1;
      // a completion with nothing outstanding is spurious and dropped
      outstanding <= outstanding + OUT_W'(accept) - OUT_W'(rd_done && outstanding != '0);
      if (state == CHECK && hit && dup_count != '1) dup_count <= dup_count + 1'b1;
      if (state == DRAIN && outstanding == '0) mig_count <= mig_count + 1'b1;
      if (hist_clear) begin
        hist_vld <= '0;
        hist_ptr <= '0;
      end else if (state == CHECK && !hit) begin
        hist_vld[hist_ptr] <= 1'b1;
        hist_ptr           <= hist_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == CHECK && !hit) hist_page[hist_ptr] <= page;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      timer    <= '0;
      query_en <= 1'b0;
    end else if (query_en) begin
      if (query_ready) begin
        query_en <= 1'b0;
        timer    <= '0;
      end
    end else if (enable) begin
      if (timer == TW'(QUERY_PERIOD - 1)) begin
        query_en <= 1'b1;
        timer    <= '0;
      end else timer <= timer + 1'b1;
    end
  end
endmodule

// File: tb/tb_mig_req_gen.sv
// tb_mig_req_gen: directed bench for mig_req_gen with hand-computed expectations.
module tb_mig_req_gen;
  logic        clk = 0, rstn = 0, enable = 0, hist_clear = 0, query_ready = 0;
  logic        mig_addr_en = 0, rd_ready = 0, done_a = 0, done_m = 0;
  logic        auto_done = 0, auto_pend = 0, rd_done;
  logic [32:0] mig_addr = '0;
  logic        query_en, mig_addr_ready, rd_valid, busy;
  logic [32:0] rd_addr;
  logic [31:0] mig_count;
  logic [15:0] dup_count;
  int          checks = 0, errors = 0;
  logic [32:0] acc_q[$];

  assign rd_done = done_a | done_m;

  mig_req_gen #(.QUERY_PERIOD(8)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .hist_clear(hist_clear),
    .query_en(query_en), .query_ready(query_ready),
    .mig_addr_en(mig_addr_en), .mig_addr(mig_addr), .mig_addr_ready(mig_addr_ready),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_done(rd_done),
    .busy(busy), .mig_count(mig_count), .dup_count(dup_count)
  );

  always #5 clk = ~clk;

  // log each handshake that will complete at the coming edge
  always @(negedge clk) begin
    auto_pend = auto_done && rd_valid && rd_ready;
    if (rd_valid && rd_ready) acc_q.push_back(rd_addr);
  end

  always @(posedge clk) begin
    #1;
    done_a = auto_pend;
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_page(logic [32:0] p);
    mig_addr    = p;
    mig_addr_en = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mig_addr_ready) break;
    end
    chk("send_ready", mig_addr_ready, 1);
    @(posedge clk);
    #1;
    mig_addr_en = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle", busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_page(string tag, logic [32:0] base);
    chk(tag, acc_q.size(), 64);
    for (int i = 0; i < acc_q.size(); i++) chk(tag, acc_q[i], base + i * 64);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    enable = 1;
    #23;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_query_en", query_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", mig_addr_ready, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_mig_count", mig_count, 0);
    chk("rst_dup_count", dup_count, 0);
    enable = 0;
    @(posedge clk);
    #1;
    rstn = 1;
    // query timer handshake
    enable = 1;
    step(7);
    chk("q_early", query_en, 0);
    step(1);
    chk("q_rise", query_en, 1);
    step(5);
    chk("q_hold", query_en, 1);
    query_ready = 1;
    step(1);
    query_ready = 0;
    chk("q_ack", query_en, 0);
    step(7);
    chk("q_early2", query_en, 0);
    step(1);
    chk("q_rise2", query_en, 1);
    // single page, immediate completions
    rd_ready  = 1;
    auto_done = 1;
    acc_q.delete();
    send_page(33'h12);
    wait_idle();
    check_page("t1_addr", 33'h12000);
    chk("t1_mig_count", mig_count, 1);
    chk("t1_dup_count", dup_count, 0);
    // duplicates and history eviction
    send_page(33'h5);
    wait_idle();
    acc_q.delete();
    send_page(33'h5);
    wait_idle();
    chk("t2_dup", dup_count, 1);
    chk("t2_dup_noreq", acc_q.size(), 0);
    for (int p = 'h21; p <= 'h28; p++) begin
      send_page(33'(p));
      wait_idle();
    end
    acc_q.delete();
    send_page(33'h5);
    wait_idle();
    check_page("t2_evicted", 33'h5000);
    acc_q.delete();
    send_page(33'h28);
    wait_idle();
    chk("t2_dup2_noreq", acc_q.size(), 0);
    chk("t2_dup2", dup_count, 2);
    chk("t2_mig_count", mig_count, 11);
    // outstanding cap and backpressure
    auto_done = 0;
    acc_q.delete();
    send_page(33'h40);
    step(30);
    chk("t3_cap_n", acc_q.size(), 16);
    chk("t3_cap_valid", rd_valid, 0);
    chk("t3_cap_addr", rd_addr, 33'h40400);
    chk("t3_cap_busy", busy, 1);
    done_m = 1;
    step(1);
    done_m = 0;
    step(10);
    chk("t3_one_more", acc_q.size(), 17);
    chk("t3_recap_valid", rd_valid, 0);
    rd_ready = 0;
    done_m   = 1;
    step(1);
    done_m = 0;
    step(2);
    chk("t3_bp_valid", rd_valid, 1);
    chk("t3_bp_addr", rd_addr, 33'h40440);
    step(3);
    chk("t3_bp_valid_hold", rd_valid, 1);
    chk("t3_bp_addr_hold", rd_addr, 33'h40440);
    chk("t3_bp_n", acc_q.size(), 17);
    rd_ready = 1;
    done_m   = 1;
    step(1);
    done_m = 0;
    step(5);
    chk("t3_simul_n", acc_q.size(), 19);
    chk("t3_simul_addr", rd_addr, 33'h404C0);
    done_m    = 1;
    auto_done = 1;
    wait_idle();
    done_m = 0;
    check_page("t3_all", 33'h40000);
    chk("t3_mig_count", mig_count, 12);
    // async reset mid-issue
    acc_q.delete();
    send_page(33'h50);
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (acc_q.size() >= 10) break;
    end
    chk("t6_line10", rd_addr, 33'h50280);
    #2;
    rstn = 0;
    #1;
    chk("t6_rd_valid", rd_valid, 0);
    chk("t6_query_en", query_en, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ready", mig_addr_ready, 0);
    chk("t6_rd_addr", rd_addr, 0);
    chk("t6_mig_count", mig_count, 0);
    chk("t6_dup_count", dup_count, 0);
    @(posedge clk);
    #1;
    rstn = 1;
    step(2);
    acc_q.delete();
    send_page(33'h3);
    wait_idle();
    check_page("t6_page3", 33'h3000);
    chk("t6_mig_after", mig_count, 1);
    // hist_clear racing a CHECK-miss insert
    acc_q.delete();
    send_page(33'h9);
    hist_clear = 1;
    step(1);
    hist_clear = 0;
    wait_idle();
    send_page(33'h9);
    wait_idle();
    chk("t7_reqs", acc_q.size(), 128);
    chk("t7_mig_count", mig_count, 3);
    chk("t7_dup_count", dup_count, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
